// File: rtl/if_id_queue_pkg.sv
// Shared IF/ID pipeline definitions: datapath width, the NOP filler instruction
// and the fetch packet carried from fetch to decode.
package if_id_queue_pkg;

  localparam int XLEN = 32;

  // addi x0,x0,0 -- what decode sees when nothing has been fetched
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_pkt_t;

endpackage

// File: rtl/if_id_queue_if.sv
// Valid/ready handshake carrying one {pc, inst} pair; used on both the fetch
// side (queue is slave) and the decode side (queue is master).
interface if_id_queue_if
  import if_id_queue_pkg::*;
  #(parameter int XLEN = if_id_queue_pkg::XLEN);

  logic            valid;
  logic            ready;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] inst;

  modport master (output valid, output pc, output inst, input ready);
  modport slave  (input valid, input pc, input inst, output ready);

endinterface

// File: rtl/if_id_queue_sync_fifo_ptrs.sv
// Read/write pointers and entry count for a power-of-two circular queue.
// Flush wins over push/pop; push/pop must already be gated by ready/valid.
module sync_fifo_ptrs
  import if_id_queue_pkg::*;
  #(parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int OCC_W = PTR_W + 1)
  (input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             flush_i,
   output logic [PTR_W-1:0] wrPtr_o,
   output logic [PTR_W-1:0] rdPtr_o,
   output logic [OCC_W-1:0] count_o);

  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [OCC_W-1:0] count_q, count_d;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (push_i) wrPtr_d = wrPtr_q + 1'b1;
      if (pop_i)  rdPtr_d = rdPtr_q + 1'b1;
      if (push_i && !pop_i)      count_d = count_q + 1'b1;
      else if (!push_i && pop_i) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  assign wrPtr_o = wrPtr_q;
  assign rdPtr_o = rdPtr_q;
  assign count_o = count_q;

endmodule

// File: rtl/if_id_queue.sv
// DEPTH-entry IF->ID buffer: fetch keeps issuing while decode stalls, with a
// saturating counter of cycles where decode held back a valid instruction.
module if_id_queue
  import if_id_queue_pkg::*;
  #(parameter int              XLEN  = if_id_queue_pkg::XLEN,
    parameter int              DEPTH = 4,
    parameter logic [XLEN-1:0] NOP   = NOP_INST,
    parameter int              CNT_W = 16,
    localparam int             PTR_W = $clog2(DEPTH),
    localparam int             OCC_W = PTR_W + 1)
  (input  logic             clk,
   input  logic             rst,
   if_id_queue_if.slave     fetchIf,
   if_id_queue_if.master    decodeIf,
   input  logic             flush_i,
   output logic [OCC_W-1:0] occupancy_o,
   output logic [CNT_W-1:0] stallCycles_o);

  logic [XLEN-1:0]  pcMem_q   [DEPTH];
  logic [XLEN-1:0]  instMem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic [OCC_W-1:0] count;
  logic [CNT_W-1:0] stallCycles_q, stallCycles_d;
  logic             push, pop;

  assign fetchIf.ready  = (count != OCC_W'(DEPTH));
  assign decodeIf.valid = (count != '0);
  assign push = fetchIf.valid && fetchIf.ready;
  assign pop  = decodeIf.valid && decodeIf.ready;

  sync_fifo_ptrs #(.DEPTH(DEPTH)) uPtrs (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush_i),
    .wrPtr_o (wrPtr),
    .rdPtr_o (rdPtr),
    .count_o (count)
  );

  always_comb begin
    stallCycles_d = stallCycles_q;
    if (decodeIf.valid && !decodeIf.ready && (stallCycles_q != '1))
      stallCycles_d = stallCycles_q + 1'b1;
  end

  // Storage is deliberately unreset; the output mux never reads it while empty.
  always_ff @(posedge clk) begin
    if (!rst) stallCycles_q <= '0;
    else      stallCycles_q <= stallCycles_d;
    if (rst && push && !flush_i) begin
      pcMem_q[wrPtr]   <= fetchIf.pc;
      instMem_q[wrPtr] <= fetchIf.inst;
    end
  end

  always_comb begin
    decodeIf.pc   = '0;
    decodeIf.inst = NOP;
    if (decodeIf.valid) begin
      decodeIf.pc   = pcMem_q[rdPtr];
      decodeIf.inst = instMem_q[rdPtr];
    end
  end

  assign occupancy_o   = count;
  assign stallCycles_o = stallCycles_q;

endmodule
